updown_hex_counter: RTL

Parametrised up/down counter with synchronous load, enable, a built-in step prescaler, wrap or saturate mode, and a terminal-count pulse. Drives one active-low hex seven-segment digit per nibble of the count. It is the general counter/display block for board-level demos and timers, replacing fixed-width down-counters with hard-wired two-digit decoders.

---
 rtl/updown_hex_counter.sv | 96 +++++++++
 1 files changed

// File: rtl/updown_hex_counter.sv
// updown_hex_counter: parametrised up/down counter with synchronous load,
// enable-gated step prescaler, wrap or saturate boundary mode, a registered
// terminal-count pulse, and one active-low hex seven-segment digit per nibble.
module updown_hex_counter #(
  parameter int unsigned    N        = 6,
  parameter logic [N-1:0]   INIT     = '0,
  parameter int unsigned    PRESCALE = 1,
  parameter bit             SAT      = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [N-1:0]                  num,
  input  logic                          en,
  input  logic                          dir,
  output logic [N-1:0]                  q,
  output logic                          tc,
  output logic [7*((N+3)/4)-1:0]        seg
);

  localparam int unsigned DIGITS = (N + 3) / 4;
  localparam int unsigned PCW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  logic [PCW-1:0]      pc;
  logic                tick;
  logic [N-1:0]        q_step;
  logic                at_bound;
  logic                step_hits_bound;
  logic [4*DIGITS-1:0] qpad;

  // Active-low g..a encoding of one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0011000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Step candidate and boundary tests for the current direction.
  always_comb begin
    tick            = en && (pc == PC_LAST);
    q_step          = dir ? (q + N'(1)) : (q - N'(1));
    at_bound        = dir ? (q == '1) : (q == '0);
    step_hits_bound = dir ? (q_step == '1) : (q_step == '0);
  end

  // Count, prescaler and terminal-count registers; rst > load > step > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= INIT;
      pc <= '0;
      tc <= 1'b0;
    end else if (load) begin
      q  <= num;
      pc <= '0;
      tc <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (en) begin
        pc <= tick ? '0 : (pc + PCW'(1));
      end
      if (tick && !(SAT && at_bound)) begin
        q  <= q_step;
        tc <= step_hits_bound;
      end
    end
  end

  // Zero-extended nibble view of q feeding the per-digit decoders.
  always_comb begin
    qpad        = '0;
    qpad[N-1:0] = q;
    seg         = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      seg[7*k +: 7] = hex7(qpad[4*k +: 4]);
    end
  end

endmodule
